// File: rtl/song_sequencer.sv
// song_sequencer: steps a synchronous note ROM at a programmable tempo with start/stop/pause; define SONG_LOOP_EN to loop the song forever
module song_sequencer #(
  parameter int ADDR_W     = 8,
  parameter int NOTE_W     = 8,
  parameter int LAST_ADDR  = 240,
  parameter int TEMPO_W    = 24,
  parameter int GAP_CYCLES = 4096
)(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic [TEMPO_W-1:0] tempo_div,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [NOTE_W-1:0]  rom_data,
  output logic [NOTE_W-1:0]  note_out,
  output logic               note_gate,
  output logic               playing,
  output logic               song_done
);
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, DONE} state_t;
  localparam logic [ADDR_W-1:0]  LAST = ADDR_W'(LAST_ADDR);
  localparam logic [TEMPO_W-1:0] GAP  = TEMPO_W'(GAP_CYCLES);
  state_t state, state_d;
  logic [TEMPO_W-1:0] cnt, cnt_d;
  logic [ADDR_W-1:0] addr_d;
  logic [NOTE_W-1:0] note_d;
  logic wrap, gate_d, playing_d, done_d;
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_d;
  // next state and next datapath values; stop overrides everything
  always_comb begin
    state_d = state;
    addr_d = rom_addr;
    note_d = note_out;
    cnt_d = cnt;
    wrap = 1'b0;
    case (state)
      IDLE, DONE: if (start) begin
        state_d = FETCH;
        addr_d = '0;
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        note_d = rom_data;
        cnt_d = tempo_div;
        state_d = PLAY;
      end
      PLAY: if (!pause) begin
        if (cnt != '0) cnt_d = cnt - 1'b1;
        else if (rom_addr == LAST) begin
`ifdef SONG_LOOP_EN
          addr_d = '0;
          state_d = FETCH;
          wrap = 1'b1;
`else
          note_d = '0;
          state_d = DONE;
`endif
        end else begin
          addr_d = rom_addr + 1'b1;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
    if (stop) begin
      state_d = IDLE;
      addr_d = '0;
      note_d = '0;
      cnt_d = '0;
    end
  end
  assign gate_d = state_d == PLAY && note_d != '0 && cnt_d >= GAP && !pause;
  assign playing_d = state_d inside {FETCH, LOAD, PLAY};
  assign done_d = state_d == DONE || wrap;
  // registered outputs and beat counter
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rom_addr <= '0;
      note_out <= '0;
      cnt <= '0;
      note_gate <= 1'b0;
      playing <= 1'b0;
      song_done <= 1'b0;
    end else begin
      rom_addr <= addr_d;
      note_out <= note_d;
      cnt <= cnt_d;
      note_gate <= gate_d;
      playing <= playing_d;
      song_done <= done_d;
    end
endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer: directed test-plan runs plus randomized control stimulus checked against a beat-level reference model
module tb_song_sequencer;
  localparam int GAP = 2;
  localparam int LAST = 3;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, stop = 1'b0, pause = 1'b0;
  logic [23:0] tempo_div = '0;
  logic [7:0] rom_addr, rom_data, note_out;
  logic note_gate, playing, song_done;
  logic [7:0] rom [0:255];
  int n_checks = 0, n_fails = 0;
  int m_mode, m_step, m_addr, m_note, m_left;
  bit m_pprev, m_pulse, pz;
  song_sequencer #(.LAST_ADDR(LAST), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
    .tempo_div(tempo_div), .rom_addr(rom_addr), .rom_data(rom_data),
    .note_out(note_out), .note_gate(note_gate), .playing(playing), .song_done(song_done)
  );
  always #5 clk = ~clk;
  always_ff @(posedge clk) rom_data <= rom[rom_addr];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_outputs();
    check("rom_addr", 32'(rom_addr), m_addr);
    check("note_out", 32'(note_out), m_note);
    check("note_gate", 32'(note_gate), 32'(m_mode == 1 && m_step == 2 && m_note != 0 && !m_pprev && m_left >= GAP));
    check("playing", 32'(playing), 32'(m_mode == 1));
    check("song_done", 32'(song_done), 32'(m_mode == 2 || m_pulse));
  endtask
  // mode: 0 idle, 1 playing, 2 done; step within a beat: 0 fetch, 1 load, 2 sounding
  task automatic model_update();
    m_pulse = 1'b0;
    if (stop) begin
      m_mode = 0; m_step = 0; m_addr = 0; m_note = 0; m_left = 0;
    end else if (m_mode != 1) begin
      if (start) begin m_mode = 1; m_step = 0; m_addr = 0; end
    end else if (m_step == 0) m_step = 1;
    else if (m_step == 1) begin
      m_note = int'(rom[m_addr]); m_left = int'(tempo_div); m_step = 2;
    end else if (!pause) begin
      if (m_left > 0) m_left--;
      else if (m_addr == LAST) begin
`ifdef SONG_LOOP_EN
        m_addr = 0; m_step = 0; m_pulse = 1'b1;
`else
        m_mode = 2; m_note = 0; m_left = 0;
`endif
      end else begin m_addr++; m_step = 0; end
    end
    m_pprev = pause;
  endtask
  task automatic step(input logic s, input logic st, input logic p, input logic [23:0] td);
    check_outputs();
    start = s; stop = st; pause = p; tempo_div = td;
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    int first;
    for (int i = 0; i < 256; i++) rom[i] = 8'd0;
    rom[0] = 8'd25; rom[1] = 8'd0; rom[2] = 8'd27; rom[3] = 8'd30;
    m_mode = 0; m_step = 0; m_addr = 0; m_note = 0; m_left = 0; m_pprev = 1'b0; m_pulse = 1'b0; pz = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs();
    reset = 1'b1;
    @(negedge clk);
    first = -1;
    for (int j = 0; j < 60; j++) begin
      if (song_done && first < 0) first = j;
      step(j == 0, 1'b0, 1'b0, 24'd9);
    end
`ifndef SONG_LOOP_EN
    check("done_cycle", 32'(first), 32'd49);
`endif
    first = -1;
    for (int j = 0; j < 70; j++) begin
      if (rom_addr == 8'd1 && first < 0) first = j;
      step(j == 0, 1'b0, j >= 6 && j <= 10, 24'd9);
    end
    check("paused_beat_len", 32'(first), 32'd18);
    for (int j = 0; j < 40; j++) step(j == 1, j == 0, 1'b0, 24'd1);
    for (int b = 0; b < 4; b++) begin
      step(1'b0, 1'b1, 1'b0, tempo_div);
      for (int i = 0; i <= LAST; i++) rom[i] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 95));
      for (int j = 0; j < 800; j++) begin
        logic [23:0] td;
        if ($urandom_range(0, 7) == 0) pz = !pz;
        td = ($urandom_range(0, 29) == 0) ? 24'($urandom_range(0, 12)) : tempo_div;
        step($urandom_range(0, 24) == 0, $urandom_range(0, 199) == 0, pz, td);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
Upstream stage of the tone generator: steps through a song held in an external synchronous note ROM at a programmable tempo. Presents one note code per beat (0 = rest) plus an articulation gate to the tone generator. Supports start/stop/pause control and flags end of song. Replaces the free-running address counter so that playback is controllable from game FSM inputs.

Parameters:
ADDR_W, 8, width of ROM address
NOTE_W, 8, width of note code (octave*12+note; 0 = rest)
LAST_ADDR, 240, address of final note of the song
TEMPO_W, 24, width of tempo divider and beat counter
GAP_CYCLES, 4096, silent cycles at end of each beat (articulation gap between repeated notes)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  single-cycle pulse: begin playback from address 0
stop  in  1  level/pulse: abort playback, return to IDLE
pause  in  1  level: freeze beat counter, mute gate
tempo_div  in  TEMPO_W  beat length minus 1, in PLAY cycles
rom_addr  out  ADDR_W  address to note ROM (ROM data valid 1 cycle later)
rom_data  in  NOTE_W  note code from ROM
note_out  out  NOTE_W  current note code to tone generator
note_gate  out  1  high = tone generator may sound note_out
playing  out  1  high in FETCH/LOAD/PLAY
song_done  out  1  high in DONE

Behaviour:
- Reset (async, reset=0): state IDLE; rom_addr=0, note_out=0, note_gate=0, playing=0, song_done=0, beat counter=0.
- States: IDLE, FETCH, LOAD, PLAY, DONE. All outputs registered.
- Priority per cycle: stop > start > pause.
- IDLE: outputs as reset. start=1 -> FETCH with rom_addr=0.
- FETCH: 1 cycle, waits out ROM latency -> LOAD.
- LOAD: note_out<=rom_data; counter<=tempo_div (sampled here only); -> PLAY. tempo_div changes mid-beat take effect next beat.
- PLAY: counter decrements by 1 per cycle while pause=0; holds while pause=1.
  - note_gate=1 iff note_out!=0, pause=0 (previous cycle), counter>=GAP_CYCLES. Gate drops 1 cycle after pause rises, returns 1 cycle after pause falls.
  - counter==0 and pause=0: if rom_addr==LAST_ADDR -> DONE; else rom_addr<=rom_addr+1, -> FETCH.
  - Beat period with pause low = tempo_div+3 cycles (PLAY tempo_div+1, FETCH 1, LOAD 1). note_gate is 0 in FETCH/LOAD.
  - tempo_div<GAP_CYCLES: note plays silent (gate never asserts); sequencing unaffected.
- DONE: song_done=1, note_out=0, note_gate=0, playing=0. start -> FETCH at address 0 (song_done clears same edge). stop -> IDLE.
- start while playing: ignored. pause in IDLE/DONE: no effect. pause in FETCH/LOAD: those complete, then hold in PLAY.
- stop in any state: next cycle IDLE, all outputs at reset values, counter cleared.
- rom_addr never exceeds LAST_ADDR; no wrap in non-loop build.

Optional Feature:
SONG_LOOP_EN
- Defined: at counter==0 on LAST_ADDR, rom_addr<=0, -> FETCH. DONE is unreachable; song_done pulses high for exactly 1 cycle (the FETCH cycle at address 0) per loop completion; playing stays 1.
- Undefined: behaviour as above (DONE terminal until start/stop).

Test Plan:
- GAP_CYCLES=2, LAST_ADDR=3, tempo_div=9, ROM {25,0,27,30}; start pulse -> rom_addr 0,1,2,3 each held 12 cycles; note_out 25,0,27,30; note_gate high 8 cycles/beat except 0 for rest; song_done=1 after 48 cycles from FETCH.
- Same setup, pause=1 for 5 cycles mid-beat 0 -> note_gate low from 1 cycle after pause rise to 1 cycle after fall; beat 0 lengthened to 17 cycles; note_out stays 25.
- stop asserted in PLAY at address 2 -> next cycle IDLE, rom_addr=0, note_out=0, note_gate=0, playing=0; subsequent start replays from address 0.
- tempo_div=1, GAP_CYCLES=2 -> every note_gate stays 0; addresses step every 4 cycles; DONE reached.
- start pulse during PLAY -> no effect on rom_addr/counter; start in DONE -> restart, song_done clears same edge.
- With SONG_LOOP_EN, LAST_ADDR=3 -> after address 3, rom_addr=0, song_done 1-cycle pulse, playing stays 1, sequence repeats twice identically.
